// File: rtl/rc_deconv.sv
// Inverse single-pole RC filter: rebuilds x[n] = y[n-1] + (y[n]-y[n-1])/alpha from the
// smoothed stream, saturating to the sample range and counting clipped outputs.
module rc_deconv #(
   parameter int                    ADC_WIDTH  = 14,
   parameter int                    GAIN_WIDTH = 24,
   parameter logic [GAIN_WIDTH-1:0] INV_GAIN   = GAIN_WIDTH'(2048),
   parameter int                    GAIN_FRAC  = 8,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [ADC_WIDTH-1:0] adc_dat_a,
   input  logic                        in_valid,
   output logic signed [ADC_WIDTH-1:0] adc_deconv_a,
   output logic                        out_valid,
   output logic                        sat_flag,
   input  logic                        sat_clr,
   output logic [CNT_WIDTH-1:0]        sat_count
);

   // state    | meaning
   // ST_PRIME | waiting for the first sample; it only seeds y_prev
   // ST_RUN   | every valid sample enters the pipeline and becomes the new y_prev
   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam int DW = ADC_WIDTH + 1;
   localparam int PW = ADC_WIDTH + GAIN_WIDTH + 2;
   localparam int SW = PW + 1;

   localparam logic signed [PW-1:0] GAIN_EXT = PW'(INV_GAIN);
   localparam logic signed [SW-1:0] MAX_S    = (SW'(1) <<< (ADC_WIDTH - 1)) - SW'(1);
   localparam logic signed [SW-1:0] MIN_S    = -MAX_S - SW'(1);

   state_t                      state_q, state_d;
   logic signed [ADC_WIDTH-1:0] y_prev_q, y_prev_d;

   logic                        s1_valid_q, s1_valid_d;
   logic signed [DW-1:0]        s1_diff_q, s1_diff_d;
   logic signed [ADC_WIDTH-1:0] s1_yp_q, s1_yp_d;

   logic                        s2_valid_q, s2_valid_d;
   logic signed [PW-1:0]        s2_prod_q, s2_prod_d;
   logic signed [ADC_WIDTH-1:0] s2_yp_q, s2_yp_d;

   logic                        s3_valid_q, s3_valid_d;
   logic signed [SW-1:0]        s3_sum_q, s3_sum_d;

   logic signed [ADC_WIDTH-1:0] adc_deconv_q, adc_deconv_d;
   logic                        out_valid_q, out_valid_d;
   logic                        sat_flag_q, sat_flag_d;
   logic [CNT_WIDTH-1:0]        sat_count_q, sat_count_d;

   logic signed [PW-1:0]        prod_shift;
   logic signed [ADC_WIDTH-1:0] clip_val;
   logic                        clip_hit;
   logic                        sat_event;

   always_comb begin
      state_d    = state_q;
      y_prev_d   = y_prev_q;
      s1_valid_d = 1'b0;
      s1_diff_d  = s1_diff_q;
      s1_yp_d    = s1_yp_q;
      case (state_q)
         ST_PRIME: begin
            if (in_valid) begin
               y_prev_d = adc_dat_a;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               s1_valid_d = 1'b1;
               s1_diff_d  = DW'(adc_dat_a) - DW'(y_prev_q);
               s1_yp_d    = y_prev_q;
               y_prev_d   = adc_dat_a;
            end
         end
         default: state_d = ST_PRIME;
      endcase
   end

   // Full-width product; the difference is at most 15 bits so nothing is lost.
   always_comb begin
      s2_valid_d = s1_valid_q;
      s2_prod_d  = s2_prod_q;
      s2_yp_d    = s2_yp_q;
      if (s1_valid_q) begin
         s2_prod_d = PW'(s1_diff_q) * GAIN_EXT;
         s2_yp_d   = s1_yp_q;
      end
   end

   always_comb begin
      prod_shift = s2_prod_q >>> GAIN_FRAC;
      s3_valid_d = s2_valid_q;
      s3_sum_d   = s3_sum_q;
      if (s2_valid_q) begin
         s3_sum_d = SW'(prod_shift) + SW'(s2_yp_q);
      end
   end

   always_comb begin
      clip_hit = 1'b0;
      clip_val = s3_sum_q[ADC_WIDTH-1:0];
      if (s3_sum_q > MAX_S) begin
         clip_hit = 1'b1;
         clip_val = {1'b0, {(ADC_WIDTH - 1){1'b1}}};
      end else if (s3_sum_q < MIN_S) begin
         clip_hit = 1'b1;
         clip_val = {1'b1, {(ADC_WIDTH - 1){1'b0}}};
      end
   end

   always_comb begin
      adc_deconv_d = adc_deconv_q;
      out_valid_d  = 1'b0;
      sat_flag_d   = 1'b0;
      if (s3_valid_q) begin
         adc_deconv_d = clip_val;
         out_valid_d  = 1'b1;
         sat_flag_d   = clip_hit;
      end
   end

   // A clear coinciding with a clipped output keeps that one event.
   assign sat_event = out_valid_q & sat_flag_q;

   always_comb begin
      sat_count_d = sat_count_q;
      if (sat_clr) begin
         sat_count_d = sat_event ? CNT_WIDTH'(1) : '0;
      end else if (sat_event && (sat_count_q != {CNT_WIDTH{1'b1}})) begin
         sat_count_d = sat_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_PRIME;
         y_prev_q     <= '0;
         s1_valid_q   <= 1'b0;
         s1_diff_q    <= '0;
         s1_yp_q      <= '0;
         s2_valid_q   <= 1'b0;
         s2_prod_q    <= '0;
         s2_yp_q      <= '0;
         s3_valid_q   <= 1'b0;
         s3_sum_q     <= '0;
         adc_deconv_q <= '0;
         out_valid_q  <= 1'b0;
         sat_flag_q   <= 1'b0;
         sat_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         y_prev_q     <= y_prev_d;
         s1_valid_q   <= s1_valid_d;
         s1_diff_q    <= s1_diff_d;
         s1_yp_q      <= s1_yp_d;
         s2_valid_q   <= s2_valid_d;
         s2_prod_q    <= s2_prod_d;
         s2_yp_q      <= s2_yp_d;
         s3_valid_q   <= s3_valid_d;
         s3_sum_q     <= s3_sum_d;
         adc_deconv_q <= adc_deconv_d;
         out_valid_q  <= out_valid_d;
         sat_flag_q   <= sat_flag_d;
         sat_count_q  <= sat_count_d;
      end
   end

   assign adc_deconv_a = adc_deconv_q;
   assign out_valid    = out_valid_q;
   assign sat_flag     = sat_flag_q;
   assign sat_count    = sat_count_q;

endmodule

// File: tb/tb_rc_deconv.sv
// Bench for rc_deconv: three gains (8.0, 8.00390625, 1.0) share one stimulus stream and are
// checked against an arithmetic model of the inverse filter.
module tb_rc_deconv;
   localparam int AW = 14;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 sat_clr;
   logic signed [AW-1:0] adc_dat_a;

   logic signed [AW-1:0] a_out, b_out, c_out;
   logic                 a_ov, b_ov, c_ov;
   logic                 a_sf, b_sf, c_sf;
   logic [15:0]          a_cnt, b_cnt, c_cnt;

   rc_deconv dut_a (.clk(clk), .reset(reset), .adc_dat_a(adc_dat_a), .in_valid(in_valid),
      .adc_deconv_a(a_out), .out_valid(a_ov), .sat_flag(a_sf), .sat_clr(sat_clr), .sat_count(a_cnt));
   rc_deconv #(.INV_GAIN(24'd2049)) dut_b (.clk(clk), .reset(reset), .adc_dat_a(adc_dat_a),
      .in_valid(in_valid), .adc_deconv_a(b_out), .out_valid(b_ov), .sat_flag(b_sf),
      .sat_clr(sat_clr), .sat_count(b_cnt));
   rc_deconv #(.INV_GAIN(24'd256)) dut_c (.clk(clk), .reset(reset), .adc_dat_a(adc_dat_a),
      .in_valid(in_valid), .adc_deconv_a(c_out), .out_valid(c_ov), .sat_flag(c_sf),
      .sat_clr(sat_clr), .sat_count(c_cnt));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int a_obs[$], b_obs[$], c_obs[$], a_cyc_obs[$];
   bit a_sf_obs[$], b_sf_obs[$];
   int sf_idle_bad = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (a_ov) begin
            a_obs.push_back(int'(a_out));
            a_sf_obs.push_back(a_sf);
            a_cyc_obs.push_back(cyc);
         end else if (a_sf) sf_idle_bad++;
         if (b_ov) begin
            b_obs.push_back(int'(b_out));
            b_sf_obs.push_back(b_sf);
         end else if (b_sf) sf_idle_bad++;
         if (c_ov) c_obs.push_back(int'(c_out));
         else if (c_sf) sf_idle_bad++;
      end
   end

   // Reference model: x = y_prev + floor((y - y_prev) * gain / 256), then clipped.
   bit m_primed;
   int m_yp;
   int exp_a[$], exp_b[$], exp_c[$], acc_cyc[$];
   bit exp_a_sf[$], exp_b_sf[$];

   function automatic int floor_div(input longint num, input longint den);
      longint q;
      q = num / den;
      if ((num % den) != 0 && num < 0) q = q - 1;
      return int'(q);
   endfunction

   function automatic int recon(input int yp, input int y, input int g);
      return yp + floor_div(longint'(y - yp) * longint'(g), 256);
   endfunction

   function automatic int clip(input int v);
      if (v > 8191) return 8191;
      if (v < -8192) return -8192;
      return v;
   endfunction

   task automatic put(input int y, input bit v);
      int ra, rb, rc;
      adc_dat_a = y[AW-1:0];
      in_valid  = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (v) begin
         if (m_primed) begin
            ra = recon(m_yp, y, 2048);
            rb = recon(m_yp, y, 2049);
            rc = recon(m_yp, y, 256);
            exp_a.push_back(clip(ra));
            exp_a_sf.push_back(ra != clip(ra));
            exp_b.push_back(clip(rb));
            exp_b_sf.push_back(rb != clip(rb));
            exp_c.push_back(clip(rc));
            acc_cyc.push_back(cyc);
         end
         m_primed = 1'b1;
         m_yp     = y;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      sat_clr  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      a_obs.delete(); b_obs.delete(); c_obs.delete(); a_cyc_obs.delete();
      a_sf_obs.delete(); b_sf_obs.delete();
      exp_a.delete(); exp_b.delete(); exp_c.delete(); acc_cyc.delete();
      exp_a_sf.delete(); exp_b_sf.delete();
      m_primed    = 1'b0;
      m_yp        = 0;
      sf_idle_bad = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; sat_clr = 1'b0; adc_dat_a = '0;
      idle(2);
      do_reset();
      n_checks++;
      if (a_out !== 14'sd0) begin n_errors++; $display("FAIL reset_out got %0d want 0", a_out); end
      n_checks++;
      if ({a_ov, b_ov, c_ov} !== 3'b000) begin n_errors++; $display("FAIL reset_valid got %b want 000", {a_ov, b_ov, c_ov}); end
      n_checks++;
      if (a_sf !== 1'b0) begin n_errors++; $display("FAIL reset_sat_flag got %b want 0", a_sf); end
      n_checks++;
      if (a_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_sat_count got %0d want 0", a_cnt); end
   endtask

   task automatic test_prime();
      do_reset();
      put(500, 1'b1);
      idle(4);
      n_checks++;
      if (a_obs.size() != 0) begin n_errors++; $display("FAIL prime_no_out got %0d outputs want 0", a_obs.size()); end
      put(500, 1'b1);
      idle(5);
      n_checks++;
      if (a_obs.size() != 1) begin n_errors++; $display("FAIL prime_count got %0d want 1", a_obs.size()); end
      else begin
         n_checks++;
         if (a_obs[0] != 500) begin n_errors++; $display("FAIL prime_value got %0d want 500", a_obs[0]); end
         n_checks++;
         if (a_cyc_obs[0] - acc_cyc[0] != 3) begin n_errors++; $display("FAIL prime_latency got %0d want 3", a_cyc_obs[0] - acc_cyc[0]); end
      end
      n_checks++;
      if (c_obs.size() != 1 || c_obs[0] != 500) begin n_errors++; $display("FAIL prime_gain1 got %0d outputs want one 500", c_obs.size()); end
   endtask

   task automatic test_step();
      do_reset();
      put(0, 1'b1);
      put(100, 1'b1);
      idle(5);
      n_checks++;
      if (a_obs.size() != 1 || a_obs[0] != 800 || a_sf_obs[0] != 1'b0) begin
         n_errors++; $display("FAIL step got n=%0d v=%0d want one 800 unflagged", a_obs.size(), a_obs.size() > 0 ? a_obs[0] : 0);
      end
      n_checks++;
      if (c_obs.size() != 1 || c_obs[0] != 100) begin n_errors++; $display("FAIL step_gain1 got n=%0d want one 100", c_obs.size()); end
   endtask

   task automatic test_floor();
      do_reset();
      put(0, 1'b1);
      put(-1, 1'b1);
      idle(5);
      n_checks++;
      if (b_obs.size() != 1 || b_obs[0] != -9) begin
         n_errors++; $display("FAIL floor got n=%0d v=%0d want one -9", b_obs.size(), b_obs.size() > 0 ? b_obs[0] : 0);
      end
      n_checks++;
      if (a_obs.size() != 1 || a_obs[0] != -8) begin n_errors++; $display("FAIL floor_gain8 got n=%0d want one -8", a_obs.size()); end
   endtask

   task automatic test_saturation();
      int ys[5] = '{0, 2000, 1000, 0, -2000};
      int ev[4] = '{8191, -6000, -7000, -8192};
      bit es[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit found;
      do_reset();
      foreach (ys[i]) put(ys[i], 1'b1);
      idle(5);
      n_checks++;
      if (a_obs.size() != 4) begin n_errors++; $display("FAIL sat_count_outputs got %0d want 4", a_obs.size()); end
      else begin
         foreach (ev[i]) begin
            n_checks++;
            if (a_obs[i] != ev[i] || a_sf_obs[i] != es[i]) begin
               n_errors++; $display("FAIL sat_value[%0d] got %0d/%b want %0d/%b", i, a_obs[i], a_sf_obs[i], ev[i], es[i]);
            end
         end
      end
      n_checks++;
      if (a_cnt !== 16'd2) begin n_errors++; $display("FAIL sat_count got %0d want 2", a_cnt); end
      put(0, 1'b1);
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
         @(negedge clk);
         if (a_ov && a_sf) begin
            sat_clr = 1'b1;
            @(posedge clk);
            #1;
            sat_clr = 1'b0;
            found = 1'b1;
         end
      end
      n_checks++;
      if (!found) begin n_errors++; $display("FAIL sat_clr_clip got no clipped strobe want one within 10 cycles"); end
      else begin
         n_checks++;
         if (a_cnt !== 16'd1) begin n_errors++; $display("FAIL sat_clr_same_cycle got %0d want 1", a_cnt); end
      end
      sat_clr = 1'b1;
      idle(1);
      sat_clr = 1'b0;
      n_checks++;
      if (a_cnt !== 16'd0) begin n_errors++; $display("FAIL sat_clr got %0d want 0", a_cnt); end
      n_checks++;
      if (sf_idle_bad != 0) begin n_errors++; $display("FAIL sat_flag_idle got %0d want 0", sf_idle_bad); end
   endtask

   task automatic test_roundtrip();
      localparam int N = 200;
      int x[N];
      do_reset();
      // Slope-3 ramp through alpha=1/8 settles to y[n] = x[n] - 21 from the first sample.
      for (int n = 0; n < N; n++) begin
         x[n] = 3 * n - 800;
         repeat ($urandom_range(0, 3)) put(int'($urandom_range(0, 16383)) - 8192, 1'b0);
         put(x[n] - 21, 1'b1);
      end
      idle(6);
      n_checks++;
      if (a_obs.size() != N - 1) begin n_errors++; $display("FAIL roundtrip_count got %0d want %0d", a_obs.size(), N - 1); end
      else begin
         for (int i = 0; i < N - 1; i++) begin
            n_checks++;
            if (a_obs[i] - x[i + 1] > 1 || x[i + 1] - a_obs[i] > 1 || a_obs[i] != exp_a[i]) begin
               n_errors++; $display("FAIL roundtrip[%0d] got %0d want %0d (ramp %0d)", i, a_obs[i], exp_a[i], x[i + 1]);
            end
         end
      end
      n_checks++;
      if (c_obs.size() != N - 1 || c_obs != exp_c) begin n_errors++; $display("FAIL roundtrip_gain1 got n=%0d want n=%0d matching delayed input", c_obs.size(), N - 1); end
   endtask

   task automatic test_random();
      localparam int N = 150;
      int na, nb;
      do_reset();
      for (int n = 0; n < N; n++) begin
         repeat ($urandom_range(0, 2)) put(int'($urandom_range(0, 16383)) - 8192, 1'b0);
         put(int'($urandom_range(0, 4095)) - 2048, 1'b1);
      end
      idle(6);
      n_checks++;
      if (a_obs.size() != exp_a.size() || b_obs.size() != exp_b.size()) begin
         n_errors++; $display("FAIL random_count got %0d/%0d want %0d/%0d", a_obs.size(), b_obs.size(), exp_a.size(), exp_b.size());
      end else begin
         na = 0; nb = 0;
         for (int i = 0; i < exp_a.size(); i++) begin
            na += exp_a_sf[i];
            nb += exp_b_sf[i];
            n_checks++;
            if (a_obs[i] != exp_a[i] || a_sf_obs[i] != exp_a_sf[i] || b_obs[i] != exp_b[i] || b_sf_obs[i] != exp_b_sf[i]) begin
               n_errors++;
               $display("FAIL random[%0d] got %0d/%b,%0d/%b want %0d/%b,%0d/%b", i, a_obs[i], a_sf_obs[i],
                        b_obs[i], b_sf_obs[i], exp_a[i], exp_a_sf[i], exp_b[i], exp_b_sf[i]);
            end
         end
         n_checks++;
         if (int'(a_cnt) != na || int'(b_cnt) != nb) begin n_errors++; $display("FAIL random_sat_count got %0d/%0d want %0d/%0d", a_cnt, b_cnt, na, nb); end
      end
      n_checks++;
      if (c_obs != exp_c || c_cnt !== 16'd0) begin n_errors++; $display("FAIL random_gain1 got n=%0d cnt=%0d want n=%0d cnt=0", c_obs.size(), c_cnt, exp_c.size()); end
      n_checks++;
      if (sf_idle_bad != 0) begin n_errors++; $display("FAIL random_sat_flag_idle got %0d want 0", sf_idle_bad); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      put(0, 1'b1);
      put(2000, 1'b1);
      idle(5);
      n_checks++;
      if (a_cnt !== 16'd1) begin n_errors++; $display("FAIL midreset_pre_count got %0d want 1", a_cnt); end
      put(5, 1'b1);
      put(6, 1'b1);
      put(7, 1'b1);
      do_reset();
      idle(6);
      n_checks++;
      if (a_obs.size() != 0 || c_obs.size() != 0) begin n_errors++; $display("FAIL midreset_flush got %0d outputs want 0", a_obs.size() + c_obs.size()); end
      n_checks++;
      if (a_cnt !== 16'd0) begin n_errors++; $display("FAIL midreset_count got %0d want 0", a_cnt); end
      put(10, 1'b1);
      put(10, 1'b1);
      idle(5);
      n_checks++;
      if (a_obs.size() != 1 || a_obs[0] != 10) begin
         n_errors++; $display("FAIL midreset_reprime got n=%0d v=%0d want one 10", a_obs.size(), a_obs.size() > 0 ? a_obs[0] : 0);
      end
   endtask

   initial begin
      test_reset();
      test_prime();
      test_step();
      test_floor();
      test_saturation();
      test_roundtrip();
      test_random();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
